btn_debounce_multi: RTL and testbench

- Parametrised successor to the single-button edge filter.
- Debounces N independent push-button inputs. Each channel has a 2-FF synchroniser and a counter-qualified state machine.
- Produces, per channel, a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between board buttons and the calculator's keypad/operator decode logic.

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_multi_if.sv | 16 +
 rtl/btn_debounce_ch.sv | 147 ++++++++++++++
 rtl/btn_debounce_multi.sv | 40 ++++
 tb/tb_btn_debounce_multi.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the multi-channel button debouncer.
// The auto-repeat defaults only matter when BTN_AUTO_REPEAT_EN is defined.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEF_N_BTN         = 5;
  localparam int unsigned DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button bundle between the board pins and the keypad/operator decode logic.
// The master drives the raw buttons. The slave (the debouncer) returns the clean
// level plus press and release strobes.
interface btn_debounce_multi_if #(
  parameter int unsigned N_BTN = 5
);

  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;

  modport master (output btn, input level, press_pulse, release_pulse);
  modport slave  (input btn, output level, press_pulse, release_pulse);

endinterface

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: a 2-FF synchroniser, a counter-qualified
// four-state FSM, and registered level/press/release outputs.
// Optional macro BTN_AUTO_REPEAT_EN adds a repeat counter. While the channel
// stays in HELD, the counter issues extra press strobes.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             meta_q, sync_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_hit;

  // Bring the raw pin into the clock domain; the FSM only ever looks at sync_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end
  end

  // State, qualification counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Next state: any sample that disagrees during a WAIT state drops back to the base state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q)                state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      HELD: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q)                 state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the transition being taken, so the level change and the strobe land on the same edge
  always_comb begin
    level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
    press_d   = ((state_q == PRESS_WAIT) && (state_d == HELD)) || repeat_hit;
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc, rep_limit;
  logic             rep_first_q, rep_first_d;

  // Repeat counter state; it only resets when the channel falls back to IDLE or PRESS_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end

  // The counter advances only on HELD->HELD cycles, so a release bounce freezes it instead of restarting it
  always_comb begin
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    repeat_hit  = 1'b0;
    rep_inc     = rep_q + 1'b1;
    rep_limit   = rep_first_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    if ((state_d == IDLE) || (state_d == PRESS_WAIT)) begin
      rep_d       = '0;
      rep_first_d = 1'b0;
    end else if ((state_q == HELD) && (state_d == HELD)) begin
      if (rep_inc == rep_limit) begin
        repeat_hit  = 1'b1;
        rep_d       = '0;
        rep_first_d = 1'b1;
      end else begin
        rep_d = rep_inc;
      end
    end
  end
`else
  logic unused_repeat_cfg;

  // Without auto-repeat, the only press strobe is the one taken on accepting a press
  assign repeat_hit        = 1'b0;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N_BTN independent debounced button channels behind one interface port.
// Optional macro BTN_AUTO_REPEAT_EN enables per-channel auto-repeat press strobes.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic clk,
  input logic rst,
  btn_debounce_multi_if.slave bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;

  // Bit i of every vector belongs to channel i; the channels share nothing but clock and reset
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_i    (bus.btn[i]),
      .level_o  (level_w[i]),
      .press_o  (press_w[i]),
      .release_o(release_w[i])
    );
  end

  assign bus.level         = level_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Testbench for btn_debounce_multi. Each scenario task drives the buttons.
// It checks against fixed edge counts and against a run-length reference model.
// BTN_AUTO_REPEAT_EN selects which repeat pattern is expected.
module tb_btn_debounce_multi;

  localparam int N      = 5;
  localparam int STABLE = 4;
  localparam int RDELAY = 10;
  localparam int RPER   = 3;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int testsRun = 0;
  int testsFailed = 0;

  btn_debounce_multi_if #(.N_BTN(N)) bus_if ();

  btn_debounce_multi #(
    .N_BTN(N), .STABLE_CYCLES(STABLE), .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference model. A level flips once STABLE+1 consecutive synchronised samples disagree with it.
  // Any agreeing sample wipes the run. Repeats are counted in cycles of uninterrupted hold.
  int runLen [N];
  int holdCnt [N];
  bit mLvl [N];
  bit prev1 [N];
  bit prev2 [N];
  logic [N-1:0] expLevel, expPress, expRelease;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        runLen[i] = 0; holdCnt[i] = 0; mLvl[i] = 0; prev1[i] = 0; prev2[i] = 0;
      end
      expLevel = '0; expPress = '0; expRelease = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit sv;
        sv = prev2[i];
        prev2[i] = prev1[i];
        prev1[i] = bus_if.btn[i];
        expPress[i] = 1'b0;
        expRelease[i] = 1'b0;
        if (sv != mLvl[i]) begin
          runLen[i]++;
          if (runLen[i] == STABLE + 1) begin
            mLvl[i] = sv;
            runLen[i] = 0;
            holdCnt[i] = 0;
            if (sv) expPress[i] = 1'b1;
            else    expRelease[i] = 1'b1;
          end
        end else begin
          if (mLvl[i] && runLen[i] == 0) begin
            holdCnt[i]++;
            if (REPEAT_ON && (holdCnt[i] == RDELAY ||
                (holdCnt[i] > RDELAY && (holdCnt[i] - RDELAY) % RPER == 0)))
              expPress[i] = 1'b1;
          end
          runLen[i] = 0;
        end
        expLevel[i] = mLvl[i];
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] value);
    bus_if.btn = value;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(N'($urandom));
    repeat (3) @(negedge clk);
    testsRun++;
    if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b/%b/%b want all zero", bus_if.level, bus_if.press_pulse, bus_if.release_pulse);
    end
    applyStimulus('0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      testsRun++;
      if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL reset_idle k=%0d: got %b/%b/%b want %b/%b/%b", k, bus_if.level, bus_if.press_pulse, bus_if.release_pulse, expLevel, expPress, expRelease);
      end
    end
  endtask

  task automatic test_clean_press();
    applyStimulus(5'b00001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus_if.press_pulse !== ((k == STABLE + 2) ? 5'b00001 : 5'b00000) ||
          bus_if.level !== ((k >= STABLE + 2) ? 5'b00001 : 5'b00000)) begin
        testsFailed++;
        $display("[TB] FAIL clean_press k=%0d: got lvl=%b pr=%b want pulse at k=%0d only on bit0", k, bus_if.level, bus_if.press_pulse, STABLE + 2);
      end
    end
    applyStimulus('0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL clean_release_model k=%0d: got %b/%b/%b want %b/%b/%b", k, bus_if.level, bus_if.press_pulse, bus_if.release_pulse, expLevel, expPress, expRelease);
      end
    end
  endtask

  task automatic test_bounce();
    for (int b = 0; b < 4; b++) begin
      applyStimulus((b % 2 == 0) ? 5'b00010 : 5'b00000);
      repeat (2) begin
        @(negedge clk);
        testsRun++;
        if (bus_if.press_pulse !== 5'b0 || bus_if.level !== 5'b0) begin
          testsFailed++;
          $display("[TB] FAIL bounce_quiet: got lvl=%b pr=%b want 0/0", bus_if.level, bus_if.press_pulse);
        end
      end
    end
    applyStimulus(5'b00010);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus_if.press_pulse !== ((k == STABLE + 2) ? 5'b00010 : 5'b00000)) begin
        testsFailed++;
        $display("[TB] FAIL bounce_press k=%0d: got pr=%b want pulse on bit1 at k=%0d only", k, bus_if.press_pulse, STABLE + 2);
      end
    end
    applyStimulus('0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_release();
    applyStimulus(5'b00100);
    repeat (10) @(negedge clk);
    testsRun++;
    if (bus_if.level !== 5'b00100) begin
      testsFailed++;
      $display("[TB] FAIL release_held: got lvl=%b want 00100", bus_if.level);
    end
    applyStimulus(5'b00000);
    repeat (2) @(negedge clk);
    applyStimulus(5'b00100);
    @(negedge clk);
    applyStimulus(5'b00000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus_if.release_pulse !== ((k == STABLE + 2) ? 5'b00100 : 5'b00000) ||
          bus_if.level !== ((k < STABLE + 2) ? 5'b00100 : 5'b00000) ||
          {bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL release_glitch k=%0d: got lvl=%b rl=%b want release on bit2 at k=%0d (model %b/%b)", k, bus_if.level, bus_if.release_pulse, STABLE + 2, expLevel, expRelease);
      end
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(5'b10001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus_if.press_pulse !== ((k == STABLE + 2) ? 5'b10001 : 5'b00000)) begin
        testsFailed++;
        $display("[TB] FAIL simultaneous k=%0d: got pr=%b want 10001 at k=%0d", k, bus_if.press_pulse, STABLE + 2);
      end
    end
    applyStimulus('0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    applyStimulus(5'b10000);
    repeat (10) @(negedge clk);
    applyStimulus(5'b10001);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_async: got %b/%b/%b want all zero", bus_if.level, bus_if.press_pulse, bus_if.release_pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      testsRun++;
      if (bus_if.press_pulse !== ((k == STABLE + 2) ? 5'b10001 : 5'b00000) ||
          {bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_repress k=%0d: got pr=%b lvl=%b want 10001 at k=%0d", k, bus_if.press_pulse, bus_if.level, STABLE + 2);
      end
    end
    applyStimulus('0);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_auto_repeat();
    int seen[$];
    int want[$];
    int relCount;
    if (REPEAT_ON) want = '{0, 10, 13, 16, 19, 22};
    else           want = '{0};
    applyStimulus(5'b01000);
    for (int k = 0; k <= STABLE + 2 + 24; k++) begin
      @(negedge clk);
      if (bus_if.press_pulse[3] === 1'b1) seen.push_back(k - (STABLE + 2));
      testsRun++;
      if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL repeat_model k=%0d: got %b/%b/%b want %b/%b/%b", k, bus_if.level, bus_if.press_pulse, bus_if.release_pulse, expLevel, expPress, expRelease);
      end
    end
    testsRun++;
    if (seen.size() != want.size()) begin
      testsFailed++;
      $display("[TB] FAIL repeat_count: got %0d press pulses want %0d", seen.size(), want.size());
    end
    for (int j = 0; j < want.size() && j < seen.size(); j++) begin
      testsRun++;
      if (seen[j] != want[j]) begin
        testsFailed++;
        $display("[TB] FAIL repeat_offset[%0d]: got HELD+%0d want HELD+%0d", j, seen[j], want[j]);
      end
    end
    applyStimulus('0);
    relCount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_if.release_pulse[3] === 1'b1) relCount++;
      testsRun++;
      if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease}) begin
        testsFailed++;
        $display("[TB] FAIL repeat_release_model k=%0d: got %b/%b/%b want %b/%b/%b", k, bus_if.level, bus_if.press_pulse, bus_if.release_pulse, expLevel, expPress, expRelease);
      end
    end
    testsRun++;
    if (relCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL repeat_release_count: got %0d want 1", relCount);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] cur;
    cur = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5, 0) == 0) cur[i] = ~cur[i];
      applyStimulus(cur);
      @(negedge clk);
      testsRun++;
      if ({bus_if.level, bus_if.press_pulse, bus_if.release_pulse} !== {expLevel, expPress, expRelease} ||
          (bus_if.press_pulse & bus_if.release_pulse) !== '0) begin
        testsFailed++;
        $display("[TB] FAIL random k=%0d: got %b/%b/%b want %b/%b/%b", k, bus_if.level, bus_if.press_pulse, bus_if.release_pulse, expLevel, expPress, expRelease);
      end
    end
  endtask

  initial begin
    bus_if.btn = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_auto_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
